branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-side partner of the fetch-stage 2-bit branch predictor.
- Holds, in program order, every prediction issued at fetch: the predicted direction plus the predictor's counter snapshot (branch ID).
- When execute resolves the oldest outstanding branch, the block compares the actual outcome with the stored prediction, sends the predictor its training update (valid, actual outcome, returned ID) and signals a mispredict.
- On a mispredict it discards all younger wrong-path entries and stalls fetch for one recovery cycle.

Parameters:
- W_BRID, 2: branch ID / counter snapshot width; matches the predictor.
- DEPTH, 4: outstanding-branch capacity; power of two, at least 2.
- W_PTR, 2: log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- push_i  in  1  fetch issued a conditional branch this cycle.
- pred_i  in  1  predicted direction for the pushed branch (1 = taken).
- pred_id_i  in  W_BRID  predictor ID/counter snapshot for the pushed branch.
- full_o  out  1  fetch must not push: queue full or in recovery.
- empty_o  out  1  no outstanding branches.
- count_o  out  W_PTR+1  number of outstanding entries.
- resolve_i  in  1  execute resolved the oldest outstanding branch.
- taken_i  in  1  actual outcome of that branch.
- upd_v_o  out  1  training update valid; drives predictor v_i.
- upd_branch_o  out  1  actual outcome; drives predictor branch_i.
- upd_id_o  out  W_BRID  stored ID; drives predictor branch_id_i.
- mispredict_o  out  1  one-cycle pulse: redirect fetch and flush younger work.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Storage: circular FIFO of DEPTH entries {pred, id}, with head/tail pointers of W_PTR bits that wrap modulo DEPTH, and a count register of W_PTR+1 bits.
- FSM states:
  - RUN: normal operation.
  - RECOVER: lasts exactly one cycle.
- Reset:
  - State enters RUN.
  - Pointers and count are cleared to 0.
  - All outputs are 0 except empty_o = 1.
  - Reset is asynchronous and abandons any in-flight entries.
- Status outputs:
  - empty_o = (count == 0), combinational.
  - full_o = (count == DEPTH) or (state == RECOVER), combinational.
- Resolve in RUN with count > 0:
  - Pop the head entry.
  - hit = (taken_i == head.pred).
  - On the next cycle (registered, latency 1): upd_v_o = 1, upd_branch_o = taken_i, upd_id_o = head.id, mispredict_o = ~hit.
  - Update outputs are single-cycle pulses. upd_branch_o and upd_id_o hold their value when upd_v_o = 0.
- Mispredict (resolve with ~hit):
  - At the same edge as the pop, count, head and tail are all cleared to 0, so every younger entry is discarded.
  - A push in the same cycle is also wrong-path and is dropped.
  - State moves to RECOVER.
- RECOVER:
  - push_i is ignored and does not set err_o.
  - resolve_i is ignored and sets err_o.
  - Returns to RUN after one cycle.
- Push in RUN:
  - Accepted if count < DEPTH, or if there is a same-cycle resolve with hit (the pop frees the slot).
  - An accepted push writes {pred_i, pred_id_i} at tail; tail then increments.
  - A push that is not accepted in RUN (full, no hitting resolve) is dropped and sets err_o.
- Simultaneous push and hitting resolve: count is unchanged; head and tail both advance.
- Resolve with count == 0 (and no same-cycle push):
  - Ignored: no update is emitted and err_o is set.
  - A same-cycle push cannot be resolved in the cycle it is written.
- err_o is cleared only by reset.
- Pointer wrap: DEPTH-1 wraps to 0 with no bubble.

Test Plan:
- Reset with reset=1 mid-traffic -> empty_o=1, full_o=0, count_o=0, upd_v_o=0, mispredict_o=0, err_o=0.
- Push {pred=1,id=2'b11}, then resolve with taken_i=1 -> next cycle upd_v_o=1, upd_branch_o=1, upd_id_o=2'b11, mispredict_o=0, count_o=0.
- Push 3 entries ({1,11},{0,01},{1,10}), then resolve the first with taken_i=0 -> next cycle mispredict_o=1, upd_id_o=2'b11, count_o=0, full_o=1 for one cycle; a push during that cycle is ignored and err_o stays 0.
- Fill to DEPTH=4 -> full_o=1; push plus resolve-hit in the same cycle -> count_o remains 4; a lone push when full -> dropped, err_o=1.
- Push and hit-resolve 10 branches back-to-back -> in-order IDs on upd_id_o, correct pointer wrap, upd_v_o high every cycle after the first.
- Resolve when empty -> no upd_v_o pulse, err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-side branch resolution queue: holds fetch predictions in program order,
// trains the 2-bit predictor on resolve and flushes wrong-path entries on mispredict.
module branch_resolve #(
  parameter int W_BRID = 2,
  parameter int DEPTH  = 4,
  parameter int W_PTR  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pred_i,
  input  logic [W_BRID-1:0] pred_id_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [W_PTR:0]    count_o,
  input  logic              resolve_i,
  input  logic              taken_i,
  output logic              upd_v_o,
  output logic              upd_branch_o,
  output logic [W_BRID-1:0] upd_id_o,
  output logic              mispredict_o,
  output logic              err_o
);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  localparam logic [W_PTR:0]   FULL_CNT = (W_PTR+1)'(DEPTH);
  localparam logic [W_PTR-1:0] PTR_ONE  = W_PTR'(1);
  localparam logic [W_PTR:0]   CNT_ONE  = (W_PTR+1)'(1);

  state_t state, state_nxt;

  logic              mem_pred [DEPTH];
  logic [W_BRID-1:0] mem_id   [DEPTH];
  logic [W_PTR-1:0]  head, tail;
  logic [W_PTR:0]    count;

  logic              run_p0;
  logic              head_pred_p0;
  logic [W_BRID-1:0] head_id_p0;
  logic              resolve_p0;
  logic              hit_p0;
  logic              flush_p0;
  logic              push_ok_p0;
  logic              err_set_p0;

  // Stage p0: decode this cycle's push/resolve against the queue head.
  always_comb begin
    run_p0       = (state == RUN);
    head_pred_p0 = mem_pred[head];
    head_id_p0   = mem_id[head];
    resolve_p0   = run_p0 & resolve_i & (count != '0);
    hit_p0       = (taken_i == head_pred_p0);
    flush_p0     = resolve_p0 & ~hit_p0;
    // A hitting pop frees the slot a same-cycle push needs when the queue is full.
    push_ok_p0   = run_p0 & push_i & ~flush_p0 &
                   ((count != FULL_CNT) | (resolve_p0 & hit_p0));
    err_set_p0   = (~run_p0 & resolve_i) |
                   (run_p0 & resolve_i & (count == '0)) |
                   (run_p0 & push_i & ~flush_p0 & ~push_ok_p0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_p0) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push_ok_p0) begin
      mem_pred[tail] <= pred_i;
      mem_id[tail]   <= pred_id_i;
    end
  end

  // Stage p1: pointer/count update and registered training outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      upd_v_o      <= 1'b0;
      upd_branch_o <= 1'b0;
      upd_id_o     <= '0;
      mispredict_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if (flush_p0) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (resolve_p0) head <= head + PTR_ONE;
        if (push_ok_p0) tail <= tail + PTR_ONE;
        case ({push_ok_p0, resolve_p0})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
      upd_v_o      <= resolve_p0;
      mispredict_o <= flush_p0;
      if (resolve_p0) begin
        upd_branch_o <= taken_i;
        upd_id_o     <= head_id_p0;
      end
      err_o <= err_o | err_set_p0;
    end
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT) | (state == RECOVER);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: expected training updates go into a queue
// and a negedge monitor pops and compares each one the DUT emits.
module tb_branch_resolve;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_i, pred_i, resolve_i, taken_i;
  logic [1:0] pred_id_i;
  logic       full_o, empty_o, upd_v_o, upd_branch_o, mispredict_o, err_o;
  logic [2:0] count_o;
  logic [1:0] upd_id_o;

  typedef struct packed {
    logic       br;
    logic [1:0] id;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  branch_resolve #(.W_BRID(2), .DEPTH(4), .W_PTR(2)) dut (
    .clk(clk), .reset(reset),
    .push_i(push_i), .pred_i(pred_i), .pred_id_i(pred_id_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .resolve_i(resolve_i), .taken_i(taken_i),
    .upd_v_o(upd_v_o), .upd_branch_o(upd_branch_o), .upd_id_o(upd_id_o),
    .mispredict_o(mispredict_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; returns 1 time unit after the active edge.
  task automatic step(input logic p, input logic pr, input logic [1:0] id,
                      input logic r, input logic tk);
    push_i = p; pred_i = pr; pred_id_i = id; resolve_i = r; taken_i = tk;
    @(posedge clk);
    #1;
    push_i = 1'b0; pred_i = 1'b0; pred_id_i = 2'b00; resolve_i = 1'b0; taken_i = 1'b0;
  endtask

  task automatic expect_upd(input logic br, input logic [1:0] id, input logic mis);
    exp_t e;
    e.br = br; e.id = id; e.mis = mis;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (upd_v_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_upd", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("upd_branch", upd_branch_o, e.br);
          chk("upd_id", upd_id_o, e.id);
          chk("mispredict", mispredict_o, e.mis);
        end
      end else begin
        if (mispredict_o) chk("stray_mispredict", mispredict_o, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] kk, pk;
    reset = 1'b1;
    push_i = 1'b0; pred_i = 1'b0; pred_id_i = 2'b00; resolve_i = 1'b0; taken_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-traffic, with err already raised and entries in flight.
    step(0, 0, 2'b00, 1, 0);
    chk("pre_reset_err", err_o, 1);
    step(1, 1, 2'b10, 0, 0);
    step(1, 0, 2'b01, 0, 0);
    chk("pre_reset_count", count_o, 2);
    #3 reset = 1'b1;
    #1;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_upd_v", upd_v_o, 0);
    chk("rst_mispredict", mispredict_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single correctly predicted branch.
    step(1, 1, 2'b11, 0, 0);
    chk("t2_count_push", count_o, 1);
    expect_upd(1, 2'b11, 0);
    step(0, 0, 2'b00, 1, 1);
    chk("t2_upd_v", upd_v_o, 1);
    chk("t2_count", count_o, 0);
    chk("t2_empty", empty_o, 1);
    step(0, 0, 2'b00, 0, 0);
    chk("t2_upd_v_drop", upd_v_o, 0);
    chk("t2_id_hold", upd_id_o, 2'b11);
    chk("t2_br_hold", upd_branch_o, 1);

    // Mispredict on oldest of three flushes the rest and blocks fetch one cycle.
    step(1, 1, 2'b11, 0, 0);
    step(1, 0, 2'b01, 0, 0);
    step(1, 1, 2'b10, 0, 0);
    chk("t3_count3", count_o, 3);
    expect_upd(0, 2'b11, 1);
    step(0, 0, 2'b00, 1, 0);
    chk("t3_count_flush", count_o, 0);
    chk("t3_full_recover", full_o, 1);
    step(1, 0, 2'b01, 0, 0);
    chk("t3_push_ignored", count_o, 0);
    chk("t3_full_clear", full_o, 0);
    chk("t3_err", err_o, 0);

    // Fill, push+hit while full, then a dropped lone push.
    step(1, 0, 2'b00, 0, 0);
    step(1, 1, 2'b01, 0, 0);
    step(1, 0, 2'b10, 0, 0);
    step(1, 1, 2'b11, 0, 0);
    chk("t4_full", full_o, 1);
    chk("t4_count4", count_o, 4);
    expect_upd(0, 2'b00, 0);
    step(1, 1, 2'b00, 1, 0);
    chk("t4_count_swap", count_o, 4);
    chk("t4_err_swap", err_o, 0);
    step(1, 0, 2'b10, 0, 0);
    chk("t4_count_drop", count_o, 4);
    chk("t4_err_drop", err_o, 1);
    expect_upd(1, 2'b01, 0);
    step(0, 0, 2'b00, 1, 1);
    expect_upd(0, 2'b10, 0);
    step(0, 0, 2'b00, 1, 0);
    expect_upd(1, 2'b11, 0);
    step(0, 0, 2'b00, 1, 1);
    expect_upd(1, 2'b00, 0);
    step(0, 0, 2'b00, 1, 1);
    chk("t4_drained", count_o, 0);
    step(0, 0, 2'b00, 0, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    chk("t4_err_cleared", err_o, 0);

    // Ten back-to-back branches, pred = bit1 of index, id = low two bits.
    kk = 4'd0;
    step(1, kk[1], kk[1:0], 0, 0);
    for (int k = 1; k < 10; k++) begin
      kk = k[3:0];
      pk = kk - 4'd1;
      expect_upd(pk[1], pk[1:0], 0);
      step(1, kk[1], kk[1:0], 1, pk[1]);
      chk("t5_upd_v", upd_v_o, 1);
      chk("t5_count", count_o, 1);
    end
    kk = 4'd9;
    expect_upd(kk[1], kk[1:0], 0);
    step(0, 0, 2'b00, 1, kk[1]);
    chk("t5_upd_v_last", upd_v_o, 1);
    chk("t5_count_end", count_o, 0);
    chk("t5_err", err_o, 0);

    // Resolve on empty: no update, sticky error until reset.
    step(0, 0, 2'b00, 1, 1);
    chk("t6_no_upd", upd_v_o, 0);
    chk("t6_err", err_o, 1);
    repeat (3) step(0, 0, 2'b00, 0, 0);
    chk("t6_err_sticky", err_o, 1);
    reset = 1'b1;
    #2 reset = 1'b0;
    chk("t6_err_reset", err_o, 0);

    step(0, 0, 2'b00, 0, 0);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
